// File: rtl/lsb_param.sv
// lsb_param: LED / switch / button peripheral with a small register map.
//
// Every raw switch and button goes through its own two-flop synchroniser
// and a saturating debounce counter. A button press (debounced 0->1) latches
// a sticky event bit. irq is the OR of all pending events.
//
// Ports
//   clk, rst      sole clock (rising edge), synchronous active-high reset
//   wr            one-cycle write strobe
//   addr          register select
//   wdata, rdata  write data / combinational read data
//   hwbtn, hwswi  raw asynchronous buttons / switches
//   leds          LED register
//   btn, swi      debounced buttons / switches
//   irq           OR of pending press events
//
// Register map
//   addr | write                         | read
//   0    | leds <= wdata                 | leds
//   1    | leds <= leds | wdata          | {swi @16, btn @0}
//   2    | leds <= leds & ~wdata         | ev
//   3    | ev   <= ev & ~wdata (W1C)     | {NBTN @16, NSWI @8, NLED @0}
module lsb_param #(
  parameter int NLED = 8,
  parameter int NSWI = 8,
  parameter int NBTN = 5,
  parameter int DBW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr,
  input  logic [1:0]      addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  input  logic [NBTN-1:0] hwbtn,
  input  logic [NSWI-1:0] hwswi,
  output logic [NLED-1:0] leds,
  output logic [NBTN-1:0] btn,
  output logic [NSWI-1:0] swi,
  output logic            irq
);

  if (NLED < 1 || NLED > 32 || NSWI < 1 || NSWI > 16 ||
      NBTN < 1 || NBTN > 16 || DBW < 2 || DBW > 24) begin : g_param_check
    $error("lsb_param: parameter out of range");
  end

  // Buttons occupy the low bits of the combined input vector.
  localparam int NIN = NBTN + NSWI;
  localparam logic [DBW-1:0] CNT_MAX = '1;

  logic [NIN-1:0]  sync1_q, sync2_q, deb_q;
  logic [DBW-1:0]  cnt_q [NIN];
  logic [NBTN-1:0] btn_dly_q;
  logic [NLED-1:0] leds_q, leds_d;
  logic [NBTN-1:0] ev_q, ev_d, ev_clr, btn_rise;

  // Synchronisers and debouncers. The counter only runs while the
  // synchronised pin disagrees with the debounced state, and saturates at
  // MAX where the new value is accepted, so it never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= {hwswi, hwbtn};
      sync2_q <= sync1_q;
      for (int i = 0; i < NIN; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i] <= sync2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DBW'(1);
        end
      end
    end
  end

  // Delayed copy of the debounced buttons: the event bit is set on the edge
  // after a rise is visible on btn.
  assign btn_rise = deb_q[NBTN-1:0] & ~btn_dly_q;

  always_comb begin
    leds_d = leds_q;
    ev_clr = '0;
    if (wr) begin
      case (addr)
        2'd0: leds_d = NLED'(wdata);
        2'd1: leds_d = leds_q | NLED'(wdata);
        2'd2: leds_d = leds_q & ~NLED'(wdata);
        2'd3: ev_clr = NBTN'(wdata);
        default: ;
      endcase
    end
    // A new press wins over a simultaneous clear.
    ev_d = (ev_q & ~ev_clr) | btn_rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds_q    <= '0;
      ev_q      <= '0;
      btn_dly_q <= '0;
    end else begin
      leds_q    <= leds_d;
      ev_q      <= ev_d;
      btn_dly_q <= deb_q[NBTN-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata = 32'(leds_q);
      2'd1: rdata = (32'(deb_q[NIN-1:NBTN]) << 16) | 32'(deb_q[NBTN-1:0]);
      2'd2: rdata = 32'(ev_q);
      2'd3: rdata = {8'd0, 8'(NBTN), 8'(NSWI), 8'(NLED)};
      default: rdata = '0;
    endcase
  end

  assign leds = leds_q;
  assign btn  = deb_q[NBTN-1:0];
  assign swi  = deb_q[NIN-1:NBTN];
  assign irq  = |ev_q;

endmodule

// File: tb/tb_lsb_param.sv
module tb_lsb_param;

  logic        clk = 1'b0;
  logic        rst, wr;
  logic [1:0]  addr;
  logic [31:0] wdata, rdata;
  logic [4:0]  hwbtn, btn;
  logic [7:0]  hwswi, swi, leds;
  logic        irq;

  logic [31:0] rdata_p;
  logic [3:0]  leds_p;
  logic [2:0]  btn_p;
  logic [1:0]  swi_p;
  logic        irq_p;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsb_param #(.NLED(8), .NSWI(8), .NBTN(5), .DBW(3)) dut (
    .clk(clk), .rst(rst), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .hwbtn(hwbtn), .hwswi(hwswi), .leds(leds), .btn(btn), .swi(swi), .irq(irq)
  );

  lsb_param #(.NLED(4), .NSWI(2), .NBTN(3), .DBW(3)) dut_p (
    .clk(clk), .rst(rst), .wr(1'b0), .addr(2'd3), .wdata(32'd0), .rdata(rdata_p),
    .hwbtn(3'd0), .hwswi(2'd0), .leds(leds_p), .btn(btn_p), .swi(swi_p), .irq(irq_p)
  );

  // Advance one rising edge; inputs are then driven / outputs sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; addr = 2'd0; wdata = '0; hwbtn = '0; hwswi = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({btn, swi, irq, leds} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_outputs got btn=%h swi=%h irq=%b leds=%h exp all 0", btn, swi, irq, leds);
    end
    for (int a = 0; a < 3; a++) begin
      addr = 2'(a);
      #1;
      n_vec++;
      if (rdata !== 32'd0) begin
        n_err++;
        $display("FAIL reset_rdata addr=%0d got=%h exp=0", a, rdata);
      end
    end
  endtask

  task automatic test_btn_debounce();
    do_reset();
    hwbtn = 5'b00001;
    addr = 2'd2;
    for (int k = 1; k <= 11; k++) begin
      tick();
      n_vec++;
      if (btn[0] !== (k >= 10)) begin
        n_err++;
        $display("FAIL btn_rise edge=%0d got=%b exp=%b", k, btn[0], (k >= 10));
      end
      if (k == 10) begin
        n_vec++;
        if (irq !== 1'b0 || rdata !== 32'd0) begin
          n_err++;
          $display("FAIL ev_early edge=10 got irq=%b ev=%h exp 0/0", irq, rdata);
        end
      end
    end
    n_vec++;
    if (irq !== 1'b1 || rdata !== 32'h1) begin
      n_err++;
      $display("FAIL ev_set edge=11 got irq=%b ev=%h exp 1/1", irq, rdata);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    addr = 2'd1;
    hwswi[3] = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 5) hwswi[3] = 1'b0;
      n_vec++;
      if (swi !== 8'd0 || rdata !== 32'd0) begin
        n_err++;
        $display("FAIL glitch edge=%0d got swi=%h rdata=%h exp 0/0", k, swi, rdata);
      end
    end
  endtask

  task automatic test_leds();
    logic [31:0] wv [4];
    logic [1:0]  wa [4];
    logic [7:0]  we [4];
    wv = '{32'hA5, 32'h0F, 32'h81, 32'hFFFF_FF5A};
    wa = '{2'd0, 2'd1, 2'd2, 2'd0};
    we = '{8'hA5, 8'hAF, 8'h2E, 8'h5A};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; addr = wa[i]; wdata = wv[i];
      tick();
      wr = 1'b0; addr = 2'd0;
      #1;
      n_vec++;
      if (leds !== we[i] || rdata !== {24'd0, we[i]}) begin
        n_err++;
        $display("FAIL leds_write step=%0d got leds=%h rdata=%h exp %h", i, leds, rdata, we[i]);
      end
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    hwbtn = 5'b00011;
    for (int k = 0; k < 11; k++) tick();
    addr = 2'd1;
    #1;
    n_vec++;
    if (rdata !== 32'h3) begin
      n_err++;
      $display("FAIL btn_read got=%h exp=3", rdata);
    end
    // Release button 0: a falling debounced state must not set an event.
    hwbtn = 5'b00010;
    addr = 2'd2;
    for (int k = 0; k < 12; k++) tick();
    n_vec++;
    if (btn !== 5'b00010 || rdata !== 32'h3) begin
      n_err++;
      $display("FAIL release got btn=%b ev=%h exp 00010/3", btn, rdata);
    end
    hwbtn = 5'b00011;
    for (int k = 0; k < 10; k++) tick();
    wr = 1'b1; addr = 2'd3; wdata = 32'h1;
    tick();
    wr = 1'b0; addr = 2'd2;
    #1;
    n_vec++;
    if (rdata !== 32'h3 || irq !== 1'b1) begin
      n_err++;
      $display("FAIL set_wins got ev=%h irq=%b exp 3/1", rdata, irq);
    end
    wr = 1'b1; addr = 2'd3; wdata = 32'h3;
    tick();
    wr = 1'b0; addr = 2'd2;
    #1;
    n_vec++;
    if (rdata !== 32'h0 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL w1c_clear got ev=%h irq=%b exp 0/0", rdata, irq);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    hwbtn = 5'b00001;
    for (int k = 0; k < 6; k++) tick();
    n_vec++;
    if (dut.cnt_q[0] !== 3'd4) begin
      n_err++;
      $display("FAIL mid_cnt got=%0d exp=4", dut.cnt_q[0]);
    end
    rst = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 32'hFF;
    tick();
    rst = 1'b0; wr = 1'b0;
    n_vec++;
    if (leds !== 8'd0 || dut.cnt_q[0] !== 3'd0 || btn !== 5'd0) begin
      n_err++;
      $display("FAIL rst_override got leds=%h cnt=%0d btn=%b exp 0", leds, dut.cnt_q[0], btn);
    end
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_vec++;
      if (btn[0] !== (k >= 10)) begin
        n_err++;
        $display("FAIL post_rst_rise edge=%0d got=%b exp=%b", k, btn[0], (k >= 10));
      end
    end
  endtask

  task automatic test_params();
    addr = 2'd3;
    #1;
    n_vec++;
    if (rdata_p !== 32'h0003_0204) begin
      n_err++;
      $display("FAIL param_read_small got=%h exp=00030204", rdata_p);
    end
    n_vec++;
    if (rdata !== 32'h0005_0808) begin
      n_err++;
      $display("FAIL param_read_default got=%h exp=00050808", rdata);
    end
  endtask

  initial begin
    test_reset();
    test_btn_debounce();
    test_glitch();
    test_leds();
    test_set_wins();
    test_reset_mid();
    test_params();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsb_param.md
LSB_PARAM -- requirements
Module: lsb_param

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NLED, 8: LED output count, 1..32.
- NSWI, 8: switch input count, 1..16.
- NBTN, 5: button input count, 1..16.
- DBW, 16: debounce counter width, 2..24; MAX = 2^DBW-1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: synchronous reset, active-high.
- wr, in, 1: write strobe, one cycle per write.
- addr, in, 2: register select.
- wdata, in, 32: write data.
- rdata, out, 32: read data.
- hwbtn, in, NBTN: raw asynchronous buttons.
- hwswi, in, NSWI: raw asynchronous switches.
- leds, out, NLED: LED register.
- btn, out, NBTN: debounced buttons.
- swi, out, NSWI: debounced switches.
- irq, out, 1: OR of all pending press events.

REQ-003 The block SHALL have one clock and a synchronous, active-high reset; clk and rst SHALL be the only clock and reset.

Function
REQ-004 Each raw input SHALL pass through a private two-flop synchroniser; sync output s = second flop.
REQ-005 Each input SHALL have a private DBW-bit counter c and a debounced state d.
REQ-006 On each edge with s == d, c SHALL load 0.
REQ-007 On each edge with s != d and c < MAX, c SHALL increment by 1.
REQ-008 On an edge with s != d and c == MAX, d SHALL load s and c SHALL load 0.
REQ-009 A pin change held stable SHALL therefore reach d exactly MAX+3 edges after the first sampling edge; a glitch shorter than MAX+1 cycles at s SHALL leave d unchanged; the counter SHALL never wrap.
REQ-010 btn and swi SHALL be the d registers directly.
REQ-011 Each button SHALL have a sticky event bit ev[i], set on the edge after d rises 0->1; a falling d SHALL NOT set ev.
REQ-012 Writes SHALL take effect on the wr edge, as follows:
- addr 0: leds <= wdata[NLED-1:0].
- addr 1: leds <= leds | wdata (set bits).
- addr 2: leds <= leds & ~wdata (clear bits).
- addr 3: ev <= ev & ~wdata[NBTN-1:0] (write-1-to-clear).
REQ-013 When a clear and a new press hit the same ev bit on the same edge, set SHALL win.
REQ-014 wdata bits above the target width SHALL be ignored.
REQ-015 rdata SHALL be combinational from registered state, with all unused bits 0:
- addr 0: leds.
- addr 1: {swi in [NSWI+15:16], btn in [NBTN-1:0]}.
- addr 2: ev in [NBTN-1:0].
- addr 3: {NBTN in [23:16], NSWI in [15:8], NLED in [7:0]}.
REQ-016 Reads SHALL have no side effects.
REQ-017 irq SHALL be the combinational OR of ev; it rises one edge after the first pending press and stays high until all ev bits are cleared.
REQ-018 Unequal parameter values SHALL require no RTL change; any parameter out of range SHALL be a synthesis-time error.

Reset
REQ-019 While rst is high at an edge, all of these SHALL load 0: leds, synchronisers, counters, d, ev. After reset: btn = 0, swi = 0, irq = 0, rdata(addr 0..2) = 0.
REQ-020 rst SHALL override wr on the same edge.
REQ-021 A debounce in progress SHALL be abandoned on reset; with the pin still asserted, a full MAX+3 interval SHALL follow reset deassertion.

Verification (DBW = 3, MAX = 7, defaults otherwise)
REQ-022 Reset, then hold hwbtn[0] = 1 from cycle 0 -> btn[0] = 1 at edge 10, not before; ev = 5'b00001 and irq = 1 at edge 11.
REQ-023 Pulse hwswi[3] high for 5 cycles, then low -> swi stays 0; rdata(addr 1) = 0 throughout.
REQ-024 Write addr 0 = 0xA5, then addr 1 = 0x0F, then addr 2 = 0x81 -> leds = 0xA5, then 0xAF, then 0x2E.
REQ-025 With ev = 5'b00011, write addr 3 = 0x1 on the same edge a debounced press sets ev[0] -> ev = 5'b00011; write addr 3 = 0x3 next -> ev = 0, irq = 0.
REQ-026 Assert rst during a debounce (c = 4) and during wr of leds = 0xFF -> leds = 0 and counters = 0 after that edge; with the pin still held, btn rises MAX+3 edges after rst falls.
REQ-027 Read addr 3 with NLED = 4, NSWI = 2, NBTN = 3 -> rdata = 0x00030204.
